// File: rtl/mul_issue_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// mul_pkg
// Shared definitions for the multiply issue/writeback controller.
//   - state_e     : controller FSM state encoding (IDLE=0, START=1, WAIT=2, HOLD=3)
//   - *_DEF       : default widths and timeout
//   - timer_width : bit width of a counter that must hold 0..max_val
// ----------------------------------------------------------------------------
package mul_pkg;

  localparam int DATA_W_DEF  = 32;
  localparam int TAG_W_DEF   = 5;
  localparam int TIMEOUT_DEF = 31;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

  function automatic int timer_width(input int max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/mul_issue_ctrl_if.sv
// ----------------------------------------------------------------------------
// mul_issue_ctrl_if
// Bundles the three channels around the multiply issue controller:
//   request   : req_valid/req_ready, req_op, req_a, req_b, req_rd, stall
//   multiplier: mul_start, mul_op, mul_a, mul_b, mul_valid, mul_result
//   writeback : wb_valid/wb_ready, wb_rd, wb_data, err_timeout
// Modports:
//   master : the controller (drives req_ready/stall, mul_*, wb_*, err_timeout)
//   slave  : the surroundings (ID/EX stage, multiplier, writeback)
// ----------------------------------------------------------------------------
interface mul_issue_ctrl_if
  import mul_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int TAG_W  = TAG_W_DEF
);

  logic              req_valid;
  logic              req_ready;
  logic              req_op;
  logic [DATA_W-1:0] req_a;
  logic [DATA_W-1:0] req_b;
  logic [TAG_W-1:0]  req_rd;
  logic              stall;

  logic              mul_start;
  logic              mul_op;
  logic [DATA_W-1:0] mul_a;
  logic [DATA_W-1:0] mul_b;
  logic              mul_valid;
  logic [DATA_W-1:0] mul_result;

  logic              wb_valid;
  logic              wb_ready;
  logic [TAG_W-1:0]  wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic              err_timeout;

  modport master (
    input  req_valid, req_op, req_a, req_b, req_rd,
    output req_ready, stall,
    output mul_start, mul_op, mul_a, mul_b,
    input  mul_valid, mul_result,
    output wb_valid, wb_rd, wb_data, err_timeout,
    input  wb_ready
  );

  modport slave (
    output req_valid, req_op, req_a, req_b, req_rd,
    input  req_ready, stall,
    input  mul_start, mul_op, mul_a, mul_b,
    output mul_valid, mul_result,
    input  wb_valid, wb_rd, wb_data, err_timeout,
    output wb_ready
  );

endinterface

// File: rtl/mul_issue_ctrl_wait_timer.sv
// ----------------------------------------------------------------------------
// mul_wait_timer
// Clearable saturating up-counter used to bound the wait for the multiplier.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   i_clr      : synchronous clear to 0 (has priority over i_en)
//   i_en       : count up by one, holding at TIMEOUT
//   o_done     : count has reached TIMEOUT
// ----------------------------------------------------------------------------
module mul_wait_timer
  import mul_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_done
);

  localparam int                 CNT_W   = timer_width(TIMEOUT);
  localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] r_count;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its inputs, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en && (r_count != CNT_MAX)) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_done = (r_count == CNT_MAX);

endmodule

// File: rtl/mul_issue_ctrl.sv
// ----------------------------------------------------------------------------
// mul_issue_ctrl
// Issue/writeback controller wrapped around a multi-cycle multiplier.
// Accepts one request, holds its operands, pulses mul_start, waits (bounded
// by TIMEOUT) for the multiplier's level valid, then offers the product and
// destination tag to writeback until accepted.
//
// Ports:
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : mul_issue_ctrl_if.master (request, multiplier, writeback)
//
// Parameters: DATA_W (operand/result width), TAG_W (tag width),
//             TIMEOUT (WAIT cycles before abort, must be >= 12)
//
// Build option: MUL_ZERO_BYPASS_EN -- when defined, a request with a zero
// operand skips the multiplier and goes straight to writeback with 0.
// ----------------------------------------------------------------------------
module mul_issue_ctrl
  import mul_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TAG_W   = TAG_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  mul_issue_ctrl_if.master   bus
);

  state_e            r_state;
  logic              r_req_ready;
  logic              r_mul_start;
  logic              r_op;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [TAG_W-1:0]  r_rd;
  logic              r_wb_valid;
  logic [DATA_W-1:0] r_wb_data;
  logic              r_err_timeout;

  logic w_timer_clr;
  logic w_timer_en;
  logic w_timer_done;
  logic w_bypass;

  // Timer is zeroed while START is active so WAIT begins counting from 0.
  assign w_timer_clr = (r_state == ST_START);
  assign w_timer_en  = (r_state == ST_WAIT);

  mul_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_timer_clr),
    .i_en   (w_timer_en),
    .o_done (w_timer_done)
  );

`ifdef MUL_ZERO_BYPASS_EN
  assign w_bypass = (bus.req_a == '0) || (bus.req_b == '0);
`else
  assign w_bypass = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_req_ready   <= 1'b1;
      r_mul_start   <= 1'b0;
      r_op          <= 1'b0;
      r_a           <= '0;
      r_b           <= '0;
      r_rd          <= '0;
      r_wb_valid    <= 1'b0;
      r_wb_data     <= '0;
      r_err_timeout <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            r_op        <= bus.req_op;
            r_a         <= bus.req_a;
            r_b         <= bus.req_b;
            r_rd        <= bus.req_rd;
            r_req_ready <= 1'b0;
            if (w_bypass) begin
              r_wb_data  <= '0;
              r_wb_valid <= 1'b1;
              r_state    <= ST_HOLD;
            end else begin
              r_mul_start <= 1'b1;
              r_state     <= ST_START;
            end
          end
        end

        ST_START: begin
          r_mul_start <= 1'b0;
          r_state     <= ST_WAIT;
        end

        // A result in the same cycle as the timeout takes priority.
        ST_WAIT: begin
          if (bus.mul_valid) begin
            r_wb_data  <= bus.mul_result;
            r_wb_valid <= 1'b1;
            r_state    <= ST_HOLD;
          end else if (w_timer_done) begin
            r_wb_data     <= '0;
            r_err_timeout <= 1'b1;
            r_wb_valid    <= 1'b1;
            r_state       <= ST_HOLD;
          end
        end

        ST_HOLD: begin
          if (bus.wb_ready) begin
            r_wb_valid  <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready   = r_req_ready;
  assign bus.stall       = bus.req_valid & ~r_req_ready;
  assign bus.mul_start   = r_mul_start;
  assign bus.mul_op      = r_op;
  assign bus.mul_a       = r_a;
  assign bus.mul_b       = r_b;
  assign bus.wb_valid    = r_wb_valid;
  assign bus.wb_rd       = r_rd;
  assign bus.wb_data     = r_wb_data;
  assign bus.err_timeout = r_err_timeout;

endmodule
